// File: rtl/alien_rocket.sv
// Alien rocket launcher: picks a live column, drops one rocket per cooldown, retires on bottom or ship hit.
// Build option: define ALIEN_ROCKET_AIMED_EN to aim at the ship column instead of choosing randomly.
module alien_rocket #(
    parameter int unsigned COL_PITCH   = 40,
    parameter int unsigned ROCKET_STEP = 3,
    parameter int unsigned COOLDOWN    = 60,
    parameter int unsigned BOTTOM      = 479,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       playing,
    input  logic       tick,
    input  logic [9:0] alienX,
    input  logic [8:0] alienY,
    input  logic [7:0] alive_mask,
    input  logic [9:0] shipX,
    input  logic       shiphit,
    output logic       alienrocket1,
    output logic [9:0] alienrocket1X,
    output logic [8:0] alienrocket1Y,
    output logic       fired
);
    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam int unsigned YW1 = YW + 1;
    localparam int unsigned SW  = 11;
    localparam int unsigned CW  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    localparam logic [1:0] ST_COOLDOWN = 2'd0;
    localparam logic [1:0] ST_SELECT   = 2'd1;
    localparam logic [1:0] ST_FLYING   = 2'd2;

    localparam logic [7:0]    LFSR_TAPS = 8'hB8;
    localparam logic [SW-1:0] X_MAX     = SW'(639);
    localparam logic [YW-1:0] Y_BOTTOM  = YW'(BOTTOM);
    localparam logic [YW1-1:0] Y_BOTTOM_W = YW1'(BOTTOM);
    localparam logic [YW-1:0] Y_STEP    = YW'(ROCKET_STEP);
    localparam logic [YW-1:0] Y_RETIRE  = YW'(BOTTOM - ROCKET_STEP);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(COOLDOWN);

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_dec;
    logic [7:0]    lfsr, lfsr_d;
    logic          rocket_d, fired_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;

    logic [SW-1:0]  centre [8];
    logic [2:0]     col;
    logic [SW-1:0]  centre_sel;
    logic [XW-1:0]  launch_x;
    logic [YW1-1:0] ysum;
    logic [YW-1:0]  launch_y;

    // Column centres at full sum width, before clamping
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            centre[i] = SW'(alienX) + SW'(i * COL_PITCH) + SW'(COL_PITCH / 2);
        end
    end

`ifdef ALIEN_ROCKET_AIMED_EN
    // Nearest live column to the ship; strict compare keeps the lower index on ties
    logic [SW-1:0] best_dist;
    logic [SW-1:0] dist;
    always_comb begin
        col       = 3'd0;
        best_dist = '1;
        dist      = '0;
        for (int i = 0; i < 8; i++) begin
            dist = (centre[i] >= SW'(shipX)) ? centre[i] - SW'(shipX) : SW'(shipX) - centre[i];
            if (alive_mask[i] && (dist < best_dist)) begin
                best_dist = dist;
                col       = 3'(i);
            end
        end
    end
`else
    // First live column at or above the random candidate, wrapping 7 -> 0
    logic       found;
    logic [2:0] idx;
    logic       ship_unused;
    assign ship_unused = ^shipX;
    always_comb begin
        col   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = lfsr[2:0] + 3'(k);
            if (!found && alive_mask[idx]) begin
                col   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        centre_sel = centre[col];
        launch_x   = (centre_sel > X_MAX) ? XW'(X_MAX) : XW'(centre_sel);
        ysum       = {1'b0, alienY} + YW1'(1);
        launch_y   = (ysum >= Y_BOTTOM_W) ? Y_BOTTOM : YW'(ysum);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rocket_d = alienrocket1;
        x_d      = alienrocket1X;
        y_d      = alienrocket1Y;
        fired_d  = 1'b0;
        lfsr_d   = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
        cnt_dec  = (tick && (cnt != '0)) ? cnt - CW'(1) : cnt;
        case (state)
            ST_COOLDOWN: begin
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (alive_mask != 8'h00) begin
                    x_d      = launch_x;
                    y_d      = launch_y;
                    rocket_d = 1'b1;
                    fired_d  = 1'b1;
                    state_d  = ST_FLYING;
                end
            end
            ST_FLYING: begin
                if (shiphit || (tick && (alienrocket1Y >= Y_RETIRE))) begin
                    rocket_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_COOLDOWN;
                end else if (tick) begin
                    y_d = alienrocket1Y + Y_STEP;
                end
            end
            default: begin
                state_d = ST_COOLDOWN;
                cnt_d   = CNT_LOAD;
            end
        endcase
    end

    // LFSR only reloads on reset; it keeps running while not playing
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !playing) begin
            state         <= ST_COOLDOWN;
            cnt           <= CNT_LOAD;
            alienrocket1  <= 1'b0;
            alienrocket1X <= '0;
            alienrocket1Y <= '0;
            fired         <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            alienrocket1  <= rocket_d;
            alienrocket1X <= x_d;
            alienrocket1Y <= y_d;
            fired         <= fired_d;
        end
    end
endmodule
